// File: rtl/uart_cmd_decoder_if.sv
// Byte-in / command-out bundle between the UART receiver side and the command decoder.
// master drives received bytes and clr_cats; slave returns status and decoded commands.
interface uart_cmd_decoder_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       clr_cats;
    logic [7:0] cat_status;
    logic       cmd_valid;
    logic [7:0] cmd_opcode;
    logic [7:0] cmd_arg;
    logic       cmd_err;
    logic       busy;

    modport master (
        output rx_data, rx_valid, clr_cats,
        input  cat_status, cmd_valid, cmd_opcode, cmd_arg, cmd_err, busy
    );

    modport slave (
        input  rx_data, rx_valid, clr_cats,
        output cat_status, cmd_valid, cmd_opcode, cmd_arg, cmd_err, busy
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Frames <op><arg><op> commands from the UART byte stream, owns cat_status; results 1 cycle after the terminator.
// Always ready: one byte per rx_valid strobe, back-to-back supported, no backpressure.
module uart_cmd_decoder #(
    parameter int         CLK_FREQ    = 103_340_000,
    parameter int         TIMEOUT_MS  = 100,
    parameter logic [7:0] OP_SHOOT    = 8'h41,
    parameter logic [7:0] OP_KEYSTORE = 8'h42,
    parameter logic [7:0] ARG_RESET   = 8'h60
) (
    input  logic               clk,
    input  logic               reset,
    uart_cmd_decoder_if.slave  bus
);
    localparam logic [31:0] TIMEOUT_CYCLES = 32'(CLK_FREQ / 1000 * TIMEOUT_MS);

    typedef enum logic [1:0] {IDLE, GOT_OP, GOT_ARG} state_t;

    state_t      state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [7:0]  arg_q, arg_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  cat_q, cat_d;
    logic [7:0]  cmd_op_q, cmd_op_d;
    logic [7:0]  cmd_arg_q, cmd_arg_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        cmd_err_q, cmd_err_d;

    logic        shoot_in_range;
    logic        shoot_reset;
    logic [2:0]  shoot_bit;

    // Full 8-bit range check so values like 8'hC1 cannot alias onto a cat bit.
    assign shoot_in_range = (arg_q >= 8'h41) && (arg_q <= 8'h48);
    assign shoot_reset    = (arg_q == ARG_RESET);
    assign shoot_bit      = arg_q[2:0] - 3'd1;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        arg_d       = arg_q;
        cnt_d       = cnt_q;
        cat_d       = cat_q;
        cmd_op_d    = cmd_op_q;
        cmd_arg_d   = cmd_arg_q;
        cmd_valid_d = 1'b0;
        cmd_err_d   = 1'b0;

        if (bus.rx_valid) begin
            cnt_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (bus.rx_data == OP_SHOOT || bus.rx_data == OP_KEYSTORE) begin
                        op_d    = bus.rx_data;
                        state_d = GOT_OP;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                GOT_OP: begin
                    arg_d   = bus.rx_data;
                    state_d = GOT_ARG;
                end
                GOT_ARG: begin
                    state_d = IDLE;
                    if (bus.rx_data != op_q) begin
                        cmd_err_d = 1'b1;
                    end else if (op_q == OP_SHOOT && !(shoot_in_range || shoot_reset)) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        cmd_valid_d = 1'b1;
                        cmd_op_d    = op_q;
                        cmd_arg_d   = arg_q;
                        if (op_q == OP_SHOOT) begin
                            if (shoot_reset) cat_d = 8'hFF;
                            else             cat_d[shoot_bit] = 1'b0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == TIMEOUT_CYCLES - 32'd1) begin
            // This edge is the one on which the count reaches the limit.
            state_d   = IDLE;
            cmd_err_d = 1'b1;
            cnt_d     = '0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end

        if (bus.clr_cats) cat_d = 8'hFF;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            arg_q       <= '0;
            cnt_q       <= '0;
            cat_q       <= 8'hFF;
            cmd_op_q    <= '0;
            cmd_arg_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            arg_q       <= arg_d;
            cnt_q       <= cnt_d;
            cat_q       <= cat_d;
            cmd_op_q    <= cmd_op_d;
            cmd_arg_q   <= cmd_arg_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign bus.cat_status = cat_q;
    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.cmd_opcode = cmd_op_q;
    assign bus.cmd_arg    = cmd_arg_q;
    assign bus.cmd_err    = cmd_err_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: table of 3-byte frames plus hand-written timing corner cases,
// with every cmd_valid/cmd_err pulse checked against a scoreboard of expected events.
module tb_uart_cmd_decoder;
    logic clk = 1'b0;
    logic reset = 1'b1;

    uart_cmd_decoder_if bus();

    // Limit = 1000/1000*50 = 50 cycles.
    uart_cmd_decoder #(.CLK_FREQ(1000), .TIMEOUT_MS(50)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] op;
        logic [7:0] arg;
        logic [7:0] cat;
    } exp_t;

    typedef struct {
        logic [7:0] b0, b1, b2;
        bit         is_err;
        logic [7:0] op, arg, cat;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endfunction

    task automatic expect_ev(bit is_err, logic [7:0] op, logic [7:0] arg, logic [7:0] cat);
        exp_t e;
        e.is_err = is_err; e.op = op; e.arg = arg; e.cat = cat;
        sb.push_back(e);
    endtask

    // Called at a negedge; drives for exactly one rising edge and returns at the next negedge.
    task automatic send_byte(logic [7:0] b, bit clr);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        bus.clr_cats = clr;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.clr_cats = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain_check(string name);
        idle(3);
        chk({name, "_drained"}, sb.size(), 0);
        chk({name, "_busy"}, bus.busy, 0);
    endtask

    always @(negedge clk) begin
        if (!reset && (bus.cmd_valid || bus.cmd_err)) begin
            chk("valid_err_exclusive", bus.cmd_valid & bus.cmd_err, 0);
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_event valid=%0b err=%0b op=%0h arg=%0h cat=%0h",
                         bus.cmd_valid, bus.cmd_err, bus.cmd_opcode, bus.cmd_arg, bus.cat_status);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ev_is_err", bus.cmd_err, e.is_err);
                chk("ev_opcode", bus.cmd_opcode, e.op);
                chk("ev_arg", bus.cmd_arg, e.arg);
                chk("ev_cat", bus.cat_status, e.cat);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        int   lat;
        bit   seen;
        logic busy_pre;

        vecs[0]  = '{8'h41, 8'h43, 8'h41, 1'b0, 8'h41, 8'h43, 8'hFB};
        vecs[1]  = '{8'h41, 8'h60, 8'h41, 1'b0, 8'h41, 8'h60, 8'hFF};
        vecs[2]  = '{8'h41, 8'h41, 8'h41, 1'b0, 8'h41, 8'h41, 8'hFE};
        vecs[3]  = '{8'h41, 8'h48, 8'h41, 1'b0, 8'h41, 8'h48, 8'h7E};
        vecs[4]  = '{8'h41, 8'h60, 8'h41, 1'b0, 8'h41, 8'h60, 8'hFF};
        vecs[5]  = '{8'h41, 8'h49, 8'h41, 1'b1, 8'h41, 8'h60, 8'hFF};
        vecs[6]  = '{8'h41, 8'h43, 8'h42, 1'b1, 8'h41, 8'h60, 8'hFF};
        vecs[7]  = '{8'h42, 8'h10, 8'h42, 1'b0, 8'h42, 8'h10, 8'hFF};
        vecs[8]  = '{8'h41, 8'h40, 8'h41, 1'b1, 8'h42, 8'h10, 8'hFF};
        vecs[9]  = '{8'h42, 8'h47, 8'h42, 1'b0, 8'h42, 8'h47, 8'hFF};
        vecs[10] = '{8'h41, 8'hC1, 8'h41, 1'b1, 8'h42, 8'h47, 8'hFF};
        vecs[11] = '{8'h42, 8'h42, 8'h41, 1'b1, 8'h42, 8'h47, 8'hFF};

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.clr_cats = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_cat", bus.cat_status, 8'hFF);
        chk("rst_opcode", bus.cmd_opcode, 8'h00);
        chk("rst_arg", bus.cmd_arg, 8'h00);
        chk("rst_valid", bus.cmd_valid, 0);
        chk("rst_err", bus.cmd_err, 0);
        chk("rst_busy", bus.busy, 0);
        reset = 1'b0;
        idle(1);

        foreach (vecs[i]) begin
            expect_ev(vecs[i].is_err, vecs[i].op, vecs[i].arg, vecs[i].cat);
            send_byte(vecs[i].b0, 1'b0); idle(1);
            send_byte(vecs[i].b1, 1'b0); idle(1);
            send_byte(vecs[i].b2, 1'b0);
            chk($sformatf("vec%0d_busy_after_last", i), bus.busy, 0);
            drain_check($sformatf("vec%0d", i));
        end

        // Bad opcode, then a mismatched terminator that must not be re-parsed as an opcode.
        expect_ev(1'b1, 8'h42, 8'h47, 8'hFF);
        send_byte(8'h43, 1'b0); idle(1);
        expect_ev(1'b0, 8'h41, 8'h46, 8'hDF);
        send_byte(8'h41, 1'b0); send_byte(8'h46, 1'b0); send_byte(8'h41, 1'b0);
        expect_ev(1'b1, 8'h41, 8'h46, 8'hDF);
        send_byte(8'h41, 1'b0); send_byte(8'h43, 1'b0); send_byte(8'h42, 1'b0);
        expect_ev(1'b0, 8'h41, 8'h44, 8'hD7);
        send_byte(8'h41, 1'b0); send_byte(8'h44, 1'b0); send_byte(8'h41, 1'b0);
        drain_check("reparse");

        // clr_cats mid-frame leaves the frame intact.
        send_byte(8'h41, 1'b0); idle(1);
        bus.clr_cats = 1'b1; @(negedge clk); bus.clr_cats = 1'b0;
        chk("clr_midframe_cat", bus.cat_status, 8'hFF);
        chk("clr_midframe_busy", bus.busy, 1);
        expect_ev(1'b0, 8'h41, 8'h42, 8'hFD);
        send_byte(8'h42, 1'b0); idle(1); send_byte(8'h41, 1'b0);
        drain_check("clr_midframe");

        // clr_cats coinciding with the completion update.
        expect_ev(1'b0, 8'h41, 8'h41, 8'hFC);
        send_byte(8'h41, 1'b0); send_byte(8'h41, 1'b0); send_byte(8'h41, 1'b0);
        expect_ev(1'b0, 8'h41, 8'h44, 8'hFF);
        send_byte(8'h41, 1'b0); idle(1); send_byte(8'h44, 1'b0); idle(1); send_byte(8'h41, 1'b1);
        drain_check("clr_coincide");

        // Inter-byte timeout.
        expect_ev(1'b1, 8'h41, 8'h44, 8'hFF);
        send_byte(8'h41, 1'b0);
        lat = 0; seen = 1'b0; busy_pre = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (c == 49) busy_pre = bus.busy;
            if (!seen && bus.cmd_err) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        chk("timeout_latency", lat, 50);
        chk("timeout_busy_before", busy_pre, 1);
        chk("timeout_busy_after", bus.busy, 0);
        @(negedge clk);
        expect_ev(1'b1, 8'h41, 8'h44, 8'hFF);
        send_byte(8'h43, 1'b0);
        drain_check("timeout_then_bad_op");

        // A byte arriving on the timeout cycle wins.
        send_byte(8'h41, 1'b0);
        repeat (49) @(posedge clk);
        @(negedge clk);
        send_byte(8'h42, 1'b0);
        chk("timeout_race_busy", bus.busy, 1);
        expect_ev(1'b0, 8'h41, 8'h42, 8'hFD);
        idle(1); send_byte(8'h41, 1'b0);
        drain_check("timeout_race");

        // Reset between arg and terminator.
        send_byte(8'h41, 1'b0); idle(1); send_byte(8'h45, 1'b0);
        reset = 1'b1;
        #2;
        chk("midrst_cat", bus.cat_status, 8'hFF);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_opcode", bus.cmd_opcode, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        expect_ev(1'b0, 8'h41, 8'h45, 8'hEF);
        send_byte(8'h41, 1'b0); idle(1); send_byte(8'h45, 1'b0); idle(1); send_byte(8'h41, 1'b0);
        drain_check("after_reset");

        // Two commands fully back-to-back.
        expect_ev(1'b0, 8'h42, 8'h11, 8'hEF);
        expect_ev(1'b0, 8'h41, 8'h46, 8'hCF);
        send_byte(8'h42, 1'b0); send_byte(8'h11, 1'b0); send_byte(8'h42, 1'b0);
        send_byte(8'h41, 1'b0); send_byte(8'h46, 1'b0); send_byte(8'h41, 1'b0);
        drain_check("back_to_back");
        chk("final_cat", bus.cat_status, 8'hCF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Byte-stream command parser directly downstream of the UART receiver.
- Consumes one received byte per valid strobe and frames 3-byte commands of the form <opcode><arg><opcode>.
- Owns the shooting-flags cat_status register and publishes every decoded command for other challenge logic.
- Replaces fixed-window frame comparison with a proper state machine, inter-byte timeout and error reporting.

Parameters:
- CLK_FREQ, 103_340_000, system clock frequency in Hz.
- TIMEOUT_MS, 100, maximum inter-byte gap inside a frame before the parser aborts.
- OP_SHOOT, 8'h41 ("A"), shooting-flags opcode.
- OP_KEYSTORE, 8'h42 ("B"), key-store opcode; decoded and forwarded only, no local effect.
- ARG_RESET, 8'h60 ("`"), shooting-flags argument that restores all cats.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  byte from UART receiver; valid only while rx_valid=1
- rx_valid  in  1  single-cycle strobe, one byte per assertion
- clr_cats  in  1  synchronous request to set cat_status to 8'hFF
- cat_status  out  8  per-cat alive bits; 1 = alive
- cmd_valid  out  1  one-cycle pulse when a well-formed command completes
- cmd_opcode  out  8  opcode of the last completed command; held between pulses
- cmd_arg  out  8  argument of the last completed command; held between pulses
- cmd_err  out  1  one-cycle pulse on any framing, argument or timeout error
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, active-high):
  - cat_status=8'hFF; cmd_opcode=0; cmd_arg=0; cmd_valid=0; cmd_err=0.
  - FSM=IDLE; timeout counter=0.
- FSM states: IDLE, GOT_OP, GOT_ARG. Transitions occur only on cycles with rx_valid=1, except timeout.
  - IDLE: opcode in {OP_SHOOT, OP_KEYSTORE} -> latch op, go to GOT_OP. Any other byte -> stay, cmd_err pulse.
  - GOT_OP: any byte -> latch arg, go to GOT_ARG.
  - GOT_ARG: byte == latched op -> command complete, go to IDLE. Byte != op -> cmd_err pulse, go to IDLE, byte discarded and not re-parsed as an opcode.
- Command completion:
  - cmd_valid, cmd_opcode and cmd_arg update on the clock edge after the terminator-byte cycle (1-cycle latency).
  - Any cat_status change for that command is applied on the same edge as the cmd_valid pulse.
- OP_SHOOT argument handling:
  - arg 8'h41..8'h48 ("A".."H") -> cat_status[arg-8'h41] <= 0.
  - arg == ARG_RESET -> cat_status <= 8'hFF.
  - Any other arg -> cmd_err pulse instead of cmd_valid; cat_status unchanged.
  - Arg range is checked on the full 8-bit value; no wrap-around or truncated index.
- OP_KEYSTORE: any arg is legal. cmd_valid pulses; cat_status is untouched.
- Timeout:
  - Counter clears on every rx_valid and while in IDLE; increments every cycle otherwise.
  - On reaching CLK_FREQ/1000*TIMEOUT_MS: FSM -> IDLE, cmd_err pulses, counter clears. Counter width is 32 bits.
  - If rx_valid coincides with the timeout cycle, the byte wins: it is processed normally and no timeout is raised.
- clr_cats:
  - Sets cat_status=8'hFF on the next edge and has no effect on the FSM.
  - When it coincides with a command-completion update, clr_cats wins (result 8'hFF); cmd_valid still pulses.
- cmd_valid and cmd_err are never asserted in the same cycle.
- Reset asserted mid-frame: the partial frame is discarded; the next byte after release is parsed as an opcode.
- Back-to-back rx_valid on consecutive cycles is supported with no dropped bytes.
- No backpressure: the block is always ready to accept a byte.

Test Plan:
- Reset, then bytes 41 43 41 with 1-cycle gaps -> one cmd_valid pulse, cmd_opcode=8'h41, cmd_arg=8'h43, cat_status=8'hFB, busy low after the last byte.
- Send 41 41 41, then 41 48 41, then 41 60 41 -> cat_status sequence 8'hFE, 8'h7E, 8'hFF; three cmd_valid pulses, no cmd_err.
- Send 41 49 41 (arg "I", just out of range) and 41 43 42 (terminator mismatch) -> two cmd_err pulses, no cmd_valid, cat_status stays 8'hFF; a following 42 10 42 gives cmd_valid with opcode 8'h42, arg 8'h10, cat_status still 8'hFF.
- With TIMEOUT_MS overridden so the limit is 50 cycles: send 41, wait 60 cycles -> cmd_err pulse at cycle 50 after the byte, busy drops. Then send 43 -> cmd_err (bad opcode), FSM stays in IDLE.
- Drive clr_cats in the same cycle that the 41 44 41 terminator update applies -> cat_status=8'hFF and cmd_valid pulses.
- Assert reset between arg and terminator of 41 45 41 -> cat_status=8'hFF, busy=0. Then 41 45 41 after release -> cat_status=8'hEF.
